// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with shift-add multiply and restoring divide over valid/ready handshakes
// Define ITER_ALU_DIV_EN to build the divider; otherwise DIVU/REMU finish in one cycle with result 0.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`ifdef ITER_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
  state_t state;
  logic [3:0] rop;
  logic [WIDTH-1:0] ra, rb, hi, lo, alu, fin;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] madd;
  logic [SW-1:0] sh;
  logic dz, is_div_in;
`ifdef ITER_ALU_DIV_EN
  logic [WIDTH:0] dsub;
  assign dsub = {hi, lo[WIDTH-1]} - {1'b0, rb};
`endif
  assign in_ready = state == IDLE;
  assign busy = state == MUL || state == DIV;
  assign is_div_in = op == 4'hD || op == 4'hE;
  always_comb begin
    sh = rb[SW-1:0];
    madd = {1'b0, hi} + (lo[0] ? {1'b0, ra} : '0);
    fin = (rop == 4'hB || rop == 4'hD) ? lo : hi;
    dz = DIV_EN && (rop == 4'hD || rop == 4'hE) && rb == '0;
    case (rop)
      4'h0: alu = ra + rb;
      4'h1: alu = ra - rb;
      4'h2: alu = ra & rb;
      4'h3: alu = ra | rb;
      4'h4: alu = ra ^ rb;
      4'h5: alu = ~(ra | rb);
      4'h6: alu = {{(WIDTH-1){1'b0}}, $signed(ra) < $signed(rb)};
      4'h7: alu = {{(WIDTH-1){1'b0}}, ra < rb};
      4'h8: alu = ra << sh;
      4'h9: alu = ra >> sh;
      4'hA: alu = $unsigned($signed(ra) >>> sh);
      4'hD: alu = DIV_EN ? '1 : '0;
      4'hE: alu = DIV_EN ? ra : '0;
      default: alu = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      div_zero <= 1'b0;
      out_tag <= '0;
      cnt <= '0;
      rop <= '0;
      ra <= '0;
      rb <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= b;
          rop <= op;
          out_tag <= in_tag;
          cnt <= '0;
          hi <= '0;
          lo <= is_div_in ? a : b;
          state <= (op == 4'hB || op == 4'hC) ? MUL :
                   (DIV_EN && is_div_in && b != '0) ? DIV : EXEC;
        end
        EXEC: begin
          result <= alu;
          zero <= rop == 4'hF ? ra == rb : alu == '0;
          div_zero <= dz;
          out_valid <= 1'b1;
          state <= DONE;
        end
        MUL: if (cnt == LAST) begin
          result <= fin;
          zero <= fin == '0;
          div_zero <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          {hi, lo} <= {madd, lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
`ifdef ITER_ALU_DIV_EN
        DIV: if (cnt == LAST) begin
          result <= fin;
          zero <= fin == '0;
          div_zero <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          hi <= dsub[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : dsub[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], ~dsub[WIDTH]};
          cnt <= cnt + 1'b1;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized and directed checks of iter_alu against an arithmetic reference model
module tb_iter_alu;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [3:0] op = 0, in_tag = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, zero, div_zero, busy;
  logic [31:0] result;
  logic [3:0] out_tag;
  int checks = 0, failures = 0;

  iter_alu #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .div_zero(div_zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic z, output logic dz, output int lat);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    dz = 0;
    lat = 1;
    case (o)
      4'h0: r = x + y;
      4'h1: r = x - y;
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = ~(x | y);
      4'h6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h7: r = (x < y) ? 32'd1 : 32'd0;
      4'h8: r = x << y[4:0];
      4'h9: r = x >> y[4:0];
      4'hA: r = $unsigned($signed(x) >>> y[4:0]);
      4'hB: begin r = p[31:0]; lat = 33; end
      4'hC: begin r = p[63:32]; lat = 33; end
      4'hD, 4'hE: begin
`ifdef ITER_ALU_DIV_EN
        if (y == 0) begin
          r = (o == 4'hD) ? 32'hFFFFFFFF : x;
          dz = 1;
        end else begin
          r = (o == 4'hD) ? x / y : x % y;
          lat = 33;
        end
`else
        r = 0;
`endif
      end
      default: r = 0;
    endcase
    z = (o == 4'hF) ? (x == y) : (r == 0);
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t, input int hold);
    logic [31:0] er;
    logic ez, edz;
    int lat, k;
    model(o, x, y, er, ez, edz, lat);
    check("accept_ready", in_ready, 1);
    op = o; a = x; b = y; in_tag = t; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom; in_tag = 4'($urandom);
    check("busy_start", busy, lat > 1);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (!out_valid) check("busy_iter", busy, 1);
    end
    check("latency", k, lat);
    check("result", result, er);
    check("zero", zero, ez);
    check("div_zero", div_zero, edz);
    check("out_tag", out_tag, t);
    check("busy_done", busy, 0);
    check("ready_done", in_ready, 0);
    repeat (hold) begin
      in_valid = 1; op = 4'($urandom); a = $urandom; b = $urandom; in_tag = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_tag", out_tag, t);
      check("hold_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_dz", div_zero, 0);
    check("rst_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    run_op(4'hF, 88, 88, 4'h1, 0);
    run_op(4'hF, 88, 87, 4'h2, 0);
    run_op(4'h1, 5, 7, 4'h3, 0);
    run_op(4'h6, 5, 7, 4'h4, 0);
    run_op(4'h7, 32'hFFFFFFFF, 7, 4'h5, 0);
    run_op(4'hA, 32'h80000000, 4, 4'h6, 0);
    run_op(4'hB, 32'h10000, 32'h10000, 4'h7, 0);
    run_op(4'hC, 32'h10000, 32'h10000, 4'h8, 0);
    run_op(4'hD, 100, 7, 4'h9, 0);
    run_op(4'hE, 100, 7, 4'hA, 0);
    run_op(4'hD, 100, 0, 4'hB, 0);
    run_op(4'hE, 100, 0, 4'hC, 0);
    run_op(4'h0, 32'hFFFFFFFF, 1, 4'hD, 5);
    run_op(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hE, 5);
    // abort a multiply part-way through with a one-cycle reset
    op = 4'hB; a = 32'h1234; b = 32'h5678; in_tag = 4'hF; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_tag", out_tag, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    run_op(4'h0, 3, 4, 4'h3, 0);
    repeat (200) begin
      logic [3:0] o;
      logic [31:0] y;
      o = 4'($urandom_range(0, 15));
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(o, $urandom, y, 4'($urandom), $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
